// File: rtl/calc_pkg.sv
// Shared constants for the stack-calculator controller: opcodes, FSM
// state encodings and default datapath sizes.
package calc_pkg;

  localparam int CALC_WIDTH = 16;
  localparam int CALC_DEPTH = 8;

  localparam logic [2:0] OP_PUSH  = 3'd0;
  localparam logic [2:0] OP_POP   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_DUP   = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/stack_calc_ctrl_if.sv
// Command channel from the keypad decoder into the stack controller.
// Handshake: a command transfers on the rising clk edge where
// cmd_valid && cmd_ready are both high; while cmd_valid is high and
// cmd_ready is low the producer holds cmd_op/cmd_data stable.
interface stack_calc_ctrl_if import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/calc_alu.sv
// Combinational arithmetic for the EXEC stage. All results wrap modulo
// 2^WIDTH; MUL keeps the low WIDTH bits of the product.
module calc_alu import calc_pkg::*; #(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result
);

  // Select the arithmetic result for the latched opcode.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_calc_ctrl.sv
// Stack-calculator sequencing controller. Accepts commands, runs them
// through IDLE->FETCH->EXEC->WRITE and drives the display value.
// Build option CALC_FRAME_SYNC_EN: when defined, `numbers` only loads
// on frame_start; otherwise it tracks the shadow register directly.
module stack_calc_ctrl import calc_pkg::*; #(
  parameter int DEPTH = CALC_DEPTH,
  parameter int WIDTH = CALC_WIDTH,
  localparam int SPW = $clog2(DEPTH + 1),
  localparam int AW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  stack_calc_ctrl_if.slave  cmd,
  input  logic              frame_start,
  output logic [WIDTH-1:0]  numbers,
  output logic [SPW-1:0]    stack_count,
  output logic              error,
  output logic [1:0]        dbg_state
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] numbers_q, numbers_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  logic             accept;
  logic             fault;
  logic [WIDTH-1:0] alu_res;
  logic [AW-1:0]    idx_top, idx_sec, idx_sp;

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_top       = AW'(sp_q - SPW'(1));
  assign idx_sec       = AW'(sp_q - SPW'(2));
  assign idx_sp        = AW'(sp_q);

  calc_alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  // Occupancy preconditions checked in FETCH; reserved opcode always faults.
  always_comb begin
    fault = 1'b0;
    case (op_q)
      OP_PUSH:                fault = (sp_q >= SPW'(DEPTH));
      OP_POP:                 fault = (sp_q == '0);
      OP_ADD, OP_SUB, OP_MUL: fault = (sp_q < SPW'(2));
      OP_DUP:                 fault = (sp_q == '0) || (sp_q >= SPW'(DEPTH));
      OP_CLEAR:               fault = 1'b0;
      OP_RSVD:                fault = 1'b1;
    endcase
  end

  // Command sequencing, operand fetch, stack pointer and shadow updates.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sp_d     = sp_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    we       = 1'b0;
    waddr    = idx_sp;
    wdata    = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd.cmd_op;
          data_d  = cmd.cmd_data;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        b_d = stack_q[idx_top];
        a_d = stack_q[idx_sec];
        if (fault) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = alu_res;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_PUSH: begin
            we       = 1'b1;
            waddr    = idx_sp;
            wdata    = data_q;
            sp_d     = sp_q + SPW'(1);
            shadow_d = data_q;
          end
          OP_POP: begin
            sp_d     = sp_q - SPW'(1);
            // Entry below the old top (A) becomes the new top, if any.
            shadow_d = (sp_q == SPW'(1)) ? '0 : a_q;
          end
          OP_DUP: begin
            we       = 1'b1;
            waddr    = idx_sp;
            wdata    = b_q;
            sp_d     = sp_q + SPW'(1);
            shadow_d = b_q;
          end
          OP_CLEAR: begin
            sp_d     = '0;
            err_d    = 1'b0;
            shadow_d = '0;
          end
          default: begin
            // ADD/SUB/MUL: result replaces the two operands.
            we       = 1'b1;
            waddr    = idx_sec;
            wdata    = res_q;
            sp_d     = sp_q - SPW'(1);
            shadow_d = res_q;
          end
        endcase
      end
    endcase
  end

  // Display register source: frame-synchronised or free-running.
`ifdef CALC_FRAME_SYNC_EN
  always_comb begin
    numbers_d = frame_start ? shadow_q : numbers_q;
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  always_comb begin
    numbers_d = shadow_q;
  end
`endif

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_PUSH;
      data_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      sp_q      <= '0;
      err_q     <= 1'b0;
      shadow_q  <= '0;
      numbers_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      shadow_q  <= shadow_d;
      numbers_q <= numbers_d;
    end
  end

  // Stack storage; a reset in the WRITE cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      stack_q[waddr] <= wdata;
    end
  end

  assign numbers     = numbers_q;
  assign stack_count = sp_q;
  assign error       = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_stack_calc_ctrl.sv
// Directed bench for stack_calc_ctrl with a reference stack model and an
// expected-result queue for per-command occupancy/error results.
module tb_stack_calc_ctrl;
  import calc_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int W     = 5;   // {stack_count[3:0], error}

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_start;
  logic [WIDTH-1:0] numbers;
  logic [3:0]       stack_count;
  logic             error;
  logic [1:0]       dbg_state;

  stack_calc_ctrl_if #(.WIDTH(WIDTH)) bus ();

  stack_calc_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (bus),
    .frame_start (frame_start),
    .numbers     (numbers),
    .stack_count (stack_count),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]     exp_q[$];
  logic [WIDTH-1:0] mstk [DEPTH];
  int               msp  = 0;
  bit               merr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_top();
    return (msp > 0) ? mstk[3'(msp - 1)] : '0;
  endfunction

  // Returns 1 when the command faults in the model.
  function automatic bit model_apply(input logic [2:0] op, input logic [WIDTH-1:0] d);
    bit               f = 1'b0;
    logic [WIDTH-1:0] a, b, r;
    case (op)
      OP_PUSH: if (msp >= DEPTH) f = 1'b1;
               else begin mstk[3'(msp)] = d; msp++; end
      OP_POP:  if (msp < 1) f = 1'b1; else msp--;
      OP_ADD, OP_SUB, OP_MUL: begin
        if (msp < 2) f = 1'b1;
        else begin
          a = mstk[3'(msp - 2)];
          b = mstk[3'(msp - 1)];
          if (op == OP_ADD)      r = a + b;
          else if (op == OP_SUB) r = a - b;
          else                   r = a * b;
          mstk[3'(msp - 2)] = r;
          msp--;
        end
      end
      OP_DUP:  if (msp < 1 || msp >= DEPTH) f = 1'b1;
               else begin mstk[3'(msp)] = mstk[3'(msp - 1)]; msp++; end
      OP_CLEAR: begin msp = 0; merr = 1'b0; end
      default: f = 1'b1;
    endcase
    if (f) merr = 1'b1;
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one command from a negedge, optionally pulsing frame_start in
  // the WRITE cycle, then checks busy duration and scoreboard result.
  task automatic send_cmd(input string tag, input logic [2:0] op,
                          input logic [WIDTH-1:0] d, input bit fs_in_write);
    int           guard;
    int           lowc;
    bit           f;
    logic [W-1:0] e;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_pre"}, 32'(bus.cmd_ready), 1);
    f = model_apply(op, d);
    exp_q.push_back({4'(msp), merr});
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    bus.cmd_data  = WIDTH'($urandom_range(0, 65535));
    lowc = 0;
    while (!bus.cmd_ready && lowc < 20) begin
      lowc++;
      frame_start = fs_in_write && (lowc == 3);
      @(negedge clk);
    end
    frame_start = 1'b0;
    check({tag, "_busy"}, 32'(lowc), f ? 1 : 3);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_count"}, 32'(stack_count), 32'(e[4:1]));
      check({tag, "_error"}, 32'(error), 32'(e[0]));
    end
  endtask

  task automatic frame_check(input string tag);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check(tag, 32'(numbers), 32'(model_top()));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset         = 1'b1;
    frame_start   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(bus.cmd_ready), 0);
    check("rst_numbers", 32'(numbers), 0);
    check("rst_count",   32'(stack_count), 0);
    check("rst_error",   32'(error), 0);
    check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready_after", 32'(bus.cmd_ready), 1);

    // 1: basic push/push/sub
    send_cmd("t1_push19", OP_PUSH, 16'h0019, 1'b0);
    send_cmd("t1_push04", OP_PUSH, 16'h0004, 1'b0);
    send_cmd("t1_sub",    OP_SUB,  16'h0000, 1'b0);
    frame_check("t1_numbers");
    check("t1_numbers_const", 32'(numbers), 32'h0015);

    // 2: multiply and wrapping add
    send_cmd("t2_clear",  OP_CLEAR, 16'h0000, 1'b0);
    send_cmd("t2_push1",  OP_PUSH,  16'h1904, 1'b0);
    send_cmd("t2_push2",  OP_PUSH,  16'h0002, 1'b0);
    send_cmd("t2_mul",    OP_MUL,   16'h0000, 1'b0);
    frame_check("t2_mul_numbers");
    check("t2_mul_const", 32'(numbers), 32'h3208);
    send_cmd("t2_push8k", OP_PUSH,  16'h8000, 1'b0);
    send_cmd("t2_dup",    OP_DUP,   16'h0000, 1'b0);
    send_cmd("t2_add",    OP_ADD,   16'h0000, 1'b0);
    frame_check("t2_wrap_numbers");
    check("t2_wrap_const", 32'(numbers), 32'h0000);
    check("t2_count2",     32'(stack_count), 2);

    // 3: underflow fault, sticky error, clear
    send_cmd("t3_clear", OP_CLEAR, 16'h0000, 1'b0);
    send_cmd("t3_add",   OP_ADD,   16'h0000, 1'b0);
    send_cmd("t3_push7", OP_PUSH,  16'h0007, 1'b0);
    frame_check("t3_push7_numbers");
    send_cmd("t3_clr2",  OP_CLEAR, 16'h0000, 1'b0);
    frame_check("t3_clear_numbers");

    // 4: overflow fault and reserved opcode
    for (int i = 1; i <= DEPTH; i++) begin
      send_cmd("t4_fill", OP_PUSH, WIDTH'(i), 1'b0);
    end
    send_cmd("t4_over", OP_PUSH, 16'h0009, 1'b0);
    frame_check("t4_top8");
    send_cmd("t4_rsvd", OP_RSVD, 16'h1234, 1'b0);
    frame_check("t4_rsvd_top");
    send_cmd("t4_pop",  OP_POP,  16'h0000, 1'b0);
    frame_check("t4_pop_top7");

    // 5: frame_start coincident with WRITE
    send_cmd("t5_clear",  OP_CLEAR, 16'h0000, 1'b0);
    send_cmd("t5_push11", OP_PUSH,  16'h0011, 1'b0);
    send_cmd("t5_pushaa", OP_PUSH,  16'h00AA, 1'b1);
    check("t5_pre_write_value", 32'(numbers), 32'h0011);
    @(negedge clk);
`ifdef CALC_FRAME_SYNC_EN
    check("t5_hold", 32'(numbers), 32'h0011);
`else
    check("t5_follow", 32'(numbers), 32'h00AA);
`endif
    frame_check("t5_next_frame");

    // 6: reset during EXEC
    send_cmd("t6_clear", OP_CLEAR, 16'h0000, 1'b0);
    send_cmd("t6_push3", OP_PUSH,  16'h0003, 1'b0);
    send_cmd("t6_push4", OP_PUSH,  16'h0004, 1'b0);
    frame_check("t6_pre_numbers");
    send_cmd("t6_rsvd",  OP_RSVD,  16'h0000, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_data  = 16'h0000;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t6_fetch", 32'(dbg_state), 32'(ST_FETCH));
    @(negedge clk);
    check("t6_exec", 32'(dbg_state), 32'(ST_EXEC));
    reset = 1'b1;
    @(negedge clk);
    msp  = 0;
    merr = 1'b0;
    check("t6_rst_count",   32'(stack_count), 0);
    check("t6_rst_numbers", 32'(numbers), 0);
    check("t6_rst_error",   32'(error), 0);
    check("t6_rst_ready",   32'(bus.cmd_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready_after", 32'(bus.cmd_ready), 1);
    check("t6_count_after", 32'(stack_count), 0);
    send_cmd("t6_push5", OP_PUSH, 16'h0005, 1'b0);
    frame_check("t6_push5_numbers");
    send_cmd("t6_pop",   OP_POP,  16'h0000, 1'b0);
    frame_check("t6_pop_empty");
    send_cmd("t6_pop_e", OP_POP,  16'h0000, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_calc_ctrl.md
Name: stack_calc_ctrl

Overview:
Sequencing controller for the stack-calculator datapath.
- Accepts keypad-decoded commands over a valid/ready handshake.
- Maintains an operand stack and runs arithmetic through a fixed-latency FSM.
- Drives the 16-bit `numbers` value consumed by picture_generator. This replaces the constant display value in the top level.
- `numbers` changes only at frame boundaries, so the rendered digits never tear mid-frame.

Parameters:
- DEPTH, 8, number of stack entries (power of 2, ≥2).
- WIDTH, 16, operand width; equals the `numbers` bus width.

Ports:
- clk  in  1  pixel clock (25 MHz domain of picture_generator).
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode.
- cmd_data  in  WIDTH  immediate for PUSH.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- numbers  out  WIDTH  value to picture_generator.
- stack_count  out  $clog2(DEPTH+1)  current occupancy.
- error  out  1  sticky fault flag.

Behaviour:
- **Clock and reset:** one clock, `clk`; `reset` is synchronous and active-high. All state is updated on the rising edge of `clk`.
- **Reset values:** numbers=0, stack_count=0, error=0, shadow=0, FSM=IDLE, cmd_ready=0 while reset is high. Stack RAM contents are don't-care.
- **Mid-operation reset:** a reset asserted mid-operation aborts the in-flight command with no partial write.
- **Opcodes:** 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 MUL, 5 DUP, 6 CLEAR, 7 reserved.
- **Handshake:**
  - Accept occurs when cmd_valid && cmd_ready.
  - cmd_ready=1 only in IDLE.
  - cmd_op and cmd_data are latched at accept.
  - Inputs are ignored while not ready; the upstream producer must hold them.
- **FSM states:** IDLE -> FETCH -> EXEC -> WRITE -> IDLE. Each state lasts one cycle, so accept-to-ready is 4 cycles.
  - FETCH: register B=stack[sp-1] (top) and A=stack[sp-2]. Check the preconditions:
    - ADD/SUB/MUL need count ≥2.
    - POP/DUP need count ≥1.
    - PUSH/DUP need count < DEPTH.
    - Op 7 is always a fault.
  - On any fault: set error, leave the stack unchanged, skip EXEC/WRITE, return to IDLE.
  - EXEC: result = A+B, A-B, or low WIDTH bits of A*B. Arithmetic is modulo 2^WIDTH with no overflow flag; SUB wraps (e.g. 0x0000-0x0001=0xFFFF).
  - WRITE:
    - PUSH: writes cmd_data at sp, sp+1.
    - Binary ops: write result at sp-2, sp-1.
    - POP: sp-1.
    - DUP: writes B at sp, sp+1.
    - CLEAR: sp=0 and error=0. CLEAR is the only command besides reset that clears error.
- **Shadow register:** updated in WRITE to the new top of stack, or 0 if the stack is now empty.
- **Display update:** `numbers` loads the shadow value on the cycle after frame_start.
  - If frame_start coincides with WRITE, the pre-WRITE shadow is taken; the new value appears at the next frame_start.
- **stack_count:** equals sp and updates at WRITE.
- **Error persistence:** error stays high across subsequent valid commands; those commands still execute.

Optional Feature:
CALC_FRAME_SYNC_EN
- Defined: `numbers` updates only on frame_start, as above.
- Undefined: frame_start is ignored and `numbers` follows the shadow register one cycle after WRITE (tearing allowed; used for faster simulation).

Decomposition:
- Package calc_pkg:
  - opcode constants OP_PUSH..OP_RSVD;
  - FSM state enum (IDLE, FETCH, EXEC, WRITE);
  - default WIDTH/DEPTH constants.
- Sub-module calc_alu: purely combinational; inputs A, B, op; output result of WIDTH bits. It is instantiated once in the EXEC path.
- Stack storage is a register array inside stack_calc_ctrl.

Test Plan:
1. Reset, then PUSH 0x0019, PUSH 0x0004, SUB, then a frame_start pulse -> numbers=0x0015, stack_count=1, error=0; cmd_ready low exactly 3 cycles after each accept.
2. PUSH 0x1904, PUSH 0x0002, MUL -> shadow 0x3208. PUSH 0x8000, DUP, ADD -> top 0x0000 (wrap), stack_count=2.
3. Empty stack, ADD -> error=1, stack_count=0. A subsequent PUSH 0x0007 executes and error stays 1. CLEAR -> error=0, count=0, numbers=0 after the next frame_start.
4. DEPTH pushes of 0x0001..0x0008, then PUSH 0x0009 -> error=1, count=8, top still 0x0008. Op 7 on a non-empty stack -> error, stack unchanged.
5. frame_start in the same cycle as WRITE of PUSH 0x00AA (previous top 0x0011) -> numbers=0x0011; at the next frame_start numbers=0x00AA. With CALC_FRAME_SYNC_EN undefined, numbers=0x00AA one cycle after WRITE.
6. Reset asserted during EXEC of ADD on [0x0003,0x0004] -> next cycle count=0, numbers=0, error=0, no write. cmd_ready rises the first cycle after reset deasserts.
